// File: rtl/riscv_defines.sv
// Shared RISC-V constants used by the instruction-memory responder and its users.
package riscv_defines;

  localparam int          WORD_WIDTH = 32;
  // Canonical NOP (addi x0, x0, 0) returned on error beats.
  localparam logic [31:0] NOOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_if.sv
// Instruction fetch bus: request/grant on the way in, rvalid/rdata/err on the way back.
interface imem_if #(
  parameter int W = 32
);

  logic         req;
  logic [W-1:0] addr;
  logic         gnt;
  logic         rvalid;
  logic [W-1:0] rdata;
  logic         err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
  // Response-only view, driven by the latency pipeline.
  modport resp   (output rvalid, rdata, err);

endinterface

// File: rtl/imem_resp_pipe.sv
// LATENCY-stage {valid, err, data} shift register; payload only advances behind a valid
// beat, so the final stage holds its last data through idle cycles.
module imem_resp_pipe #(
  parameter int W       = 32,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_err,
  input  logic [W-1:0] in_data,
  imem_if.resp         out
);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] err;
  logic [W-1:0]       dat [LATENCY];

  // NOTE: registered state uses non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      err <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        err[0] <= in_err;
        dat[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          err[i] <= err[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out.rvalid = vld[LATENCY-1];
  assign out.err    = vld[LATENCY-1] & err[LATENCY-1];
  assign out.rdata  = dat[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: preloadable word storage answering fetches in order
// after a fixed latency, with NOP/err responses for misaligned or out-of-range fetches.
module imem_responder #(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  stall_i,
  input  logic                  prog_we_i,
  input  logic [WORD_WIDTH-1:0] prog_addr_i,
  input  logic [WORD_WIDTH-1:0] prog_wdata_i
);

  localparam int AW = $clog2(MEM_WORDS);

  imem_if #(.W(WORD_WIDTH)) bus ();

  logic [WORD_WIDTH-1:0] mem [MEM_WORDS];
  logic                  fetch_err;
  logic [WORD_WIDTH-1:0] fetch_data;

  function automatic logic addr_bad(input logic [WORD_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (|a[WORD_WIDTH-1:AW+2]);
  endfunction

  assign bus.req  = instr_req_i;
  assign bus.addr = instr_addr_i;
  // Program writes win over fetches, so a write and a read never share a cycle.
  assign bus.gnt  = bus.req & ~stall_i & ~prog_we_i & ~rst;

  // NOTE: storage is deliberately left out of reset; a preloaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we_i && !addr_bad(prog_addr_i)) mem[prog_addr_i[AW+1:2]] <= prog_wdata_i;
  end

  assign fetch_err  = addr_bad(bus.addr);
  assign fetch_data = fetch_err ? WORD_WIDTH'(riscv_defines::NOOP_INSTR)
                                : mem[bus.addr[AW+1:2]];

  imem_resp_pipe #(
    .W       (WORD_WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.gnt),
    .in_err   (fetch_err),
    .in_data  (fetch_data),
    .out      (bus)
  );

  assign instr_gnt_o    = bus.gnt;
  assign instr_rvalid_o = bus.rvalid;
  assign instr_rdata_o  = bus.rdata;
  assign instr_err_o    = bus.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed plus randomized bench for imem_responder, checked against a queue-based
// model of in-order responses due LATENCY cycles after each grant.
module tb_imem_responder;

  localparam int LAT = 2;
  localparam int MW  = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  always #5 clk = ~clk;

  imem_if #(.W(32)) bus ();

  imem_responder #(
    .WORD_WIDTH (32),
    .MEM_WORDS  (MW),
    .LATENCY    (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_i    (bus.req),
    .instr_addr_i   (bus.addr),
    .instr_gnt_o    (bus.gnt),
    .instr_rvalid_o (bus.rvalid),
    .instr_rdata_o  (bus.rdata),
    .instr_err_o    (bus.err),
    .stall_i        (stall),
    .prog_we_i      (prog_we),
    .prog_addr_i    (prog_addr),
    .prog_wdata_i   (prog_wdata)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [MW];
  logic [31:0] last_rdata;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * MW));
  endfunction

  // One clock cycle: drive inputs, check the combinational grant, then check the
  // response outputs as seen just after the next rising edge.
  task automatic cycle(input logic rq, input logic [31:0] ad, input logic st,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd);
    exp_t e;
    bit   granted;
    bus.req    = rq;
    bus.addr   = ad;
    stall      = st;
    prog_we    = we;
    prog_addr  = wa;
    prog_wdata = wd;
    #1;
    granted = rq && !st && !we && !rst;
    check("gnt", 32'(bus.gnt), 32'(granted));
    if (rst) begin
      q.delete();
      last_rdata = '0;
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
    end
    if (granted) begin
      e.due  = cyc + LAT;
      e.err  = is_err(ad);
      e.data = e.err ? NOP : mm[ad[11:2]];
      q.push_back(e);
    end
    if (we && !is_err(wa)) mm[wa[11:2]] = wd;
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rvalid", 32'(bus.rvalid), 32'd1);
      check("err", 32'(bus.err), 32'(q[0].err));
      check("rdata", bus.rdata, q[0].data);
      last_rdata = q[0].data;
      void'(q.pop_front());
    end else begin
      check("idle_rvalid", 32'(bus.rvalid), 32'd0);
      check("idle_err", 32'(bus.err), 32'd0);
      check("idle_rdata", bus.rdata, last_rdata);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ad;
    logic [31:0] wa;
    logic        rq;
    logic        st;
    logic        we;
    bus.req = 1'b0; bus.addr = '0; stall = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    last_rdata = '0;

    // Reset: outputs zero and no grant even with a request pending.
    #2 rst = 1'b1;
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    idle(1);

    // Preload words 0..63; word 0 holds addi x1, x0, 5.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0050_0093);
    for (int i = 1; i < 64; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom);

    // Single fetch of address 0.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Back-to-back fetches to 0x0, 0x4, 0x8.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Misaligned and out-of-range fetches.
    cycle(1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Stall held for three cycles, then released with the request still up.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Reset one cycle after a grant drops the in-flight response.
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    idle(4);

    // Program write and fetch in the same cycle, then fetch the new word.
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Misaligned and out-of-range program writes are ignored.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h11, 32'h1111_1111);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h1010, 32'h2222_2222);
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Randomized traffic over the preloaded region plus error addresses.
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom % 4) != 0;
      st = ($urandom % 8) == 0;
      we = ($urandom % 10) == 0;
      case ($urandom % 8)
        0:       ad = {22'h0, 8'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        1:       ad = 32'h1000 + ($urandom % 32'h0010_0000);
        default: ad = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      endcase
      wa = {22'h0, 8'($urandom_range(0, 63)), (($urandom % 6) == 0) ? 2'b01 : 2'b00};
      cycle(rq, ad, st, we, wa, $urandom);
    end
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
